imem_responder: RTL
===================

Name: imem_responder

Overview:
Responder end of the instruction-fetch interface. It receives the word address driven by the IF stage and returns the 32-bit instruction one cycle later, with stall hold and branch-flush support. After reset it zero-fills its storage with NOPs, then serves fetches. A byte-strobed load port lets a loader write the program image.

Parameters:
ADDR_W, 14, width of word address (matches IF word address im_addr[13:0] = pc[15:2])
DEPTH, 1024, number of 32-bit words implemented; must be a power of 2 and <= 2**ADDR_W
INIT_FILL, 1, 1 = run NOP-fill sequence after reset; 0 = go straight to READY

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
im_addr  in  ADDR_W  word fetch address from IF stage
fetch_en  in  1  1 = advance fetch this cycle (IF not stalled)
flush  in  1  1 = discard the fetch in flight (taken jump/branch)
im_inst  out  32  instruction returned for the previous accepted fetch
im_valid  out  1  im_inst holds a live instruction
im_ready  out  1  initialisation done, fetch/load accepted
ld_en  in  1  load-port write request
ld_addr  in  ADDR_W  load word address
ld_data  in  32  load data
ld_strb  in  4  byte enables; bit i writes ld_data[8i+7:8i]
ld_ack  out  1  one-cycle pulse, load request accepted
addr_err  out  1  one-cycle pulse, out-of-range fetch or load address

Behaviour:
- Reset (rst=0, async): state=INIT if INIT_FILL else READY; fill_cnt=0; im_inst=32'h0000_0013 (NOP); im_valid=0; im_ready=0; ld_ack=0; addr_err=0. Memory contents are not reset.
- States: INIT, READY. READY is terminal until the next reset.
- INIT: each cycle write NOP to mem[fill_cnt] and increment fill_cnt. When fill_cnt==DEPTH-1, write the last word and go to READY. This takes exactly DEPTH cycles after reset release.
- INIT: im_ready=0. fetch_en, flush and ld_en are ignored: no ld_ack, no addr_err, outputs hold their reset values.
- Reset asserted mid-INIT: fill restarts from 0.
- READY: im_ready=1, registered, so it is first seen in cycle DEPTH after reset release.
- Fetch, latency 1: if fetch_en=1 and flush=0, the next edge loads im_inst<=mem[im_addr] and sets im_valid<=1.
- Stall: fetch_en=0 and flush=0 holds im_inst and im_valid unchanged.
- Flush: flush=1 takes priority over fetch_en. The next edge loads im_inst<=NOP and im_valid<=0.
- Out-of-range fetch (im_addr>=DEPTH, with fetch_en=1 and flush=0): im_inst<=NOP, im_valid<=1, addr_err<=1 for one cycle.
- In-range index = im_addr[$clog2(DEPTH)-1:0].
- Load (READY, ld_en=1): bytes selected by ld_strb are written at the edge, and ld_acknowledge ld_ack<=1 for the following cycle. Back-to-back loads each get an ack. ld_strb=0 is still acked, with no write.
- Out-of-range load: write dropped, ld_ack<=1, addr_err<=1.
- Same cycle, in-range fetch and load to the same address: write-first. im_inst returns old word bytes merged with the newly written bytes per ld_strb.
- Same cycle, out-of-range fetch and out-of-range load: single addr_err pulse.
- No other arithmetic. fill_cnt is $clog2(DEPTH) bits and never wraps; the transition happens at DEPTH-1.

Decomposition:
- Package imem_pkg holds:
  - constant NOP_INST = 32'h0000_0013
  - enum imem_state_t {INIT, READY}
  - default ADDR_W
- Sub-module imem_array: DEPTH x 32 synchronous RAM with one byte-strobed write port and one registered read port, including the write-first bypass.
- imem_responder holds the FSM, fill counter, range checks, flush/stall control and output registers.

Test Plan:
- DEPTH=16, INIT_FILL=1, release rst -> im_ready=0 for cycles 0..15, 1 at cycle 16; then fetch addr 0..15 -> every im_inst=32'h0000_0013, im_valid=1.
- Load addr 5 data 32'hDEAD_BEEF strb 4'hF, then fetch 5 with fetch_en=1 -> ld_ack pulses one cycle; next cycle im_inst=32'hDEAD_BEEF, im_valid=1.
- Fetch addr 5 then fetch_en=0 for 3 cycles with im_addr changing -> im_inst stays 32'hDEAD_BEEF, im_valid=1; then flush=1 -> next cycle im_inst=NOP, im_valid=0.
- Same cycle: load addr 7 data 32'h1122_3344 strb 4'b0011, fetch addr 7 (word was NOP) -> im_inst=32'h0000_3344, ld_ack=1.
- Fetch addr 20 and load addr 18 with DEPTH=16 -> addr_err one-cycle pulse, im_inst=NOP, im_valid=1, memory unchanged.
- Assert rst mid-INIT at cycle 8, release -> im_ready rises exactly 16 cycles after release; fetch/ld_en during INIT produce no ld_ack and no output change.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants, state encoding and the byte-merge helper for the instruction memory responder.
package imem_pkg;

    localparam int          ADDR_W_DEFAULT = 14;
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;

    typedef enum logic {
        INIT,
        READY
    } imem_state_t;

    // Byte lanes with a set strobe come from new_word, the rest keep old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 synchronous RAM: one byte-strobed write port, one registered read port.
// A read and write to the same word in the same cycle returns the freshly merged word.
module imem_array
    import imem_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            if (wr_en && (wr_idx == rd_idx)) begin
                rd_data <= merge_bytes(mem[rd_idx], wr_data, wr_strb);
            end else begin
                rd_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Responder end of the instruction-fetch interface: NOP fill after reset, then
// single-cycle-latency fetches with stall/flush, plus a byte-strobed load port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DEPTH     = 1024,
    parameter int INIT_FILL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] im_addr,
    input  logic              fetch_en,
    input  logic              flush,
    output logic [31:0]       im_inst,
    output logic              im_valid,
    output logic              im_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [3:0]        ld_strb,
    output logic              ld_ack,
    output logic              addr_err
);

    localparam int               IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam imem_state_t      RST_STATE = (INIT_FILL != 0) ? INIT : READY;

    imem_state_t      state, state_next;
    logic [IDX_W-1:0] fill_cnt;
    logic             nop_sel;
    logic [31:0]      rd_data;

    logic             fetch_oor, ld_oor, fetch_go, is_ready;
    logic             arr_wr_en, arr_rd_en;
    logic [IDX_W-1:0] arr_wr_idx;
    logic [31:0]      arr_wr_data;
    logic [3:0]       arr_wr_strb;

    assign fetch_oor = {1'b0, im_addr} >= DEPTH_LIM;
    assign ld_oor    = {1'b0, ld_addr} >= DEPTH_LIM;
    assign is_ready  = (state == READY);
    assign fetch_go  = fetch_en && !flush;

    // During INIT the write port belongs to the fill sequence; afterwards to the loader.
    always_comb begin
        state_next  = state;
        arr_wr_en   = 1'b0;
        arr_wr_idx  = ld_addr[IDX_W-1:0];
        arr_wr_data = ld_data;
        arr_wr_strb = ld_strb;
        arr_rd_en   = 1'b0;
        case (state)
            INIT: begin
                arr_wr_en   = 1'b1;
                arr_wr_idx  = fill_cnt;
                arr_wr_data = NOP_INST;
                arr_wr_strb = 4'hF;
                if (fill_cnt == LAST_IDX) begin
                    state_next = READY;
                end
            end
            READY: begin
                arr_wr_en = ld_en && !ld_oor;
                arr_rd_en = fetch_go && !fetch_oor;
            end
            default: state_next = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RST_STATE;
            fill_cnt <= '0;
            nop_sel  <= 1'b1;
            im_valid <= 1'b0;
            im_ready <= 1'b0;
            ld_ack   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_next;
            im_ready <= (state_next == READY);
            ld_ack   <= is_ready && ld_en;
            addr_err <= is_ready && ((fetch_go && fetch_oor) || (ld_en && ld_oor));
            if ((state == INIT) && (fill_cnt != LAST_IDX)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            // nop_sel overrides the RAM output so flushes and bad fetches return NOP
            // while a stall simply leaves both the RAM register and nop_sel untouched.
            if (is_ready) begin
                if (flush) begin
                    nop_sel  <= 1'b1;
                    im_valid <= 1'b0;
                end else if (fetch_en) begin
                    nop_sel  <= fetch_oor;
                    im_valid <= 1'b1;
                end
            end
        end
    end

    assign im_inst = nop_sel ? NOP_INST : rd_data;

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_idx  (arr_wr_idx),
        .wr_data (arr_wr_data),
        .wr_strb (arr_wr_strb),
        .rd_en   (arr_rd_en),
        .rd_idx  (im_addr[IDX_W-1:0]),
        .rd_data (rd_data)
    );

endmodule
